// File: rtl/csa_acc_ctrl.sv
// csa_acc_ctrl: sequential multi-operand accumulator controller.
// Operands arrive over a valid/ready stream and are packed into groups of 8.
// Each group and the running partial sum go through one 9-input carry-save
// tree with a final carry-propagate add, so one tree serves runs of any length.
// Optional feature macro: CSA_ACC_OVF_EN adds a sticky `ovf` output that flags
// wrap-around of the NBITS-wide sum.

package packConv;
  localparam int NBITS = 16;
endpackage

module csa_acc_ctrl #(
  parameter int NBITS = packConv::NBITS,
  parameter int CW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    num_ops,
  input  logic             op_valid,
  input  logic [NBITS-1:0] op_data,
  output logic             op_ready,
  output logic             sum_valid,
  output logic [NBITS-1:0] sum_data,
  input  logic             sum_ready,
  output logic             busy
`ifdef CSA_ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Tree width: 4 guard bits hold the carry-out of acc + 8 operands.
`ifdef CSA_ACC_OVF_EN
  localparam int TW = NBITS + 4;
`else
  localparam int TW = NBITS;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ADD     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q;
  logic [NBITS-1:0] acc_q;
  logic [3:0]       cnt_q;
  logic [CW-1:0]    remaining_q;
  logic [NBITS-1:0] buf_q [8];
  logic             op_ready_q;
  logic             sum_valid_q;
  logic [NBITS-1:0] sum_data_q;
  logic             busy_q;
`ifdef CSA_ACC_OVF_EN
  logic             ovf_q;
`endif

  logic [TW-1:0] tin  [9];
  logic [TW-1:0] lvl1 [6];
  logic [TW-1:0] lvl2 [4];
  logic [TW-1:0] lvl3 [3];
  logic [TW-1:0] lvl4 [2];
  logic [TW-1:0] tree_res;

  // 3:2 compressor: {carry << 1, sum}, carry truncated to the tree width.
  function automatic logic [2*TW-1:0] fa(input logic [TW-1:0] a,
                                         input logic [TW-1:0] b,
                                         input logic [TW-1:0] c);
    logic [TW-1:0] s;
    logic [TW-1:0] cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {cy, s};
  endfunction

  // 9-input carry-save reduction (9->6->4->3->2) plus final add.
  always_comb begin
    tin[0] = TW'(acc_q);
    for (int unsigned i = 0; i < 8; i++) begin
      tin[i+1] = TW'(buf_q[i]);
    end
    {lvl1[1], lvl1[0]} = fa(tin[0], tin[1], tin[2]);
    {lvl1[3], lvl1[2]} = fa(tin[3], tin[4], tin[5]);
    {lvl1[5], lvl1[4]} = fa(tin[6], tin[7], tin[8]);
    {lvl2[1], lvl2[0]} = fa(lvl1[0], lvl1[1], lvl1[2]);
    {lvl2[3], lvl2[2]} = fa(lvl1[3], lvl1[4], lvl1[5]);
    {lvl3[1], lvl3[0]} = fa(lvl2[0], lvl2[1], lvl2[2]);
    lvl3[2]            = lvl2[3];
    {lvl4[1], lvl4[0]} = fa(lvl3[0], lvl3[1], lvl3[2]);
    tree_res           = lvl4[0] + lvl4[1];
  end

  // Control FSM with registered outputs; outputs track the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      remaining_q <= '0;
      buf_q       <= '{default: '0};
      op_ready_q  <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef CSA_ACC_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            remaining_q <= num_ops;
            acc_q       <= '0;
            cnt_q       <= '0;
            buf_q       <= '{default: '0};
            busy_q      <= 1'b1;
`ifdef CSA_ACC_OVF_EN
            ovf_q       <= 1'b0;
`endif
            if (num_ops == '0) begin
              state_q     <= DONE;
              sum_valid_q <= 1'b1;
              sum_data_q  <= '0;
            end else begin
              state_q    <= COLLECT;
              op_ready_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (op_valid) begin
            buf_q[cnt_q[2:0]] <= op_data;
            cnt_q             <= cnt_q + 4'd1;
            remaining_q       <= remaining_q - 1'b1;
            if (cnt_q == 4'd7 || remaining_q == CW'(1)) begin
              state_q    <= ADD;
              op_ready_q <= 1'b0;
            end
          end
        end
        ADD: begin
          acc_q <= tree_res[NBITS-1:0];
          cnt_q <= '0;
          buf_q <= '{default: '0};
`ifdef CSA_ACC_OVF_EN
          ovf_q <= ovf_q | (|tree_res[TW-1:NBITS]);
`endif
          if (remaining_q == '0) begin
            state_q     <= DONE;
            sum_valid_q <= 1'b1;
            sum_data_q  <= tree_res[NBITS-1:0];
          end else begin
            state_q    <= COLLECT;
            op_ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (sum_ready) begin
            state_q     <= IDLE;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready  = op_ready_q;
  assign sum_valid = sum_valid_q;
  assign sum_data  = sum_data_q;
  assign busy      = busy_q;
`ifdef CSA_ACC_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_acc_ctrl.sv
// Directed self-checking bench for csa_acc_ctrl (NBITS=16, CW=8).
module tb_csa_acc_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_ops = '0;
  logic        op_valid = 1'b0;
  logic [15:0] op_data = '0;
  logic        op_ready;
  logic        sum_valid;
  logic [15:0] sum_data;
  logic        sum_ready = 1'b0;
  logic        busy;
`ifdef CSA_ACC_OVF_EN
  logic        ovf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned add_at [4];
  int unsigned n_adds = 0;

  always #5 clock = ~clock;

  csa_acc_ctrl #(.NBITS(16), .CW(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .num_ops  (num_ops),
    .op_valid (op_valid),
    .op_data  (op_data),
    .op_ready (op_ready),
    .sum_valid(sum_valid),
    .sum_data (sum_data),
    .sum_ready(sum_ready),
    .busy     (busy)
`ifdef CSA_ACC_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts a run of n operands (base + step*k), feeds them until sum_valid.
  // low = cycles with op_ready low while running, lat = last handshake -> sum_valid.
  task automatic do_run(input int unsigned n, input logic [15:0] base, input logic [15:0] step,
                        input bit toggle, output int unsigned low, output int unsigned lat);
    int unsigned hs   = 0;
    int unsigned last = 0;
    int unsigned cyc  = 0;
    bit          done = 1'b0;
    low    = 0;
    lat    = 0;
    n_adds = 0;
    start   = 1'b1;
    num_ops = 8'(n);
    tick();
    start = 1'b0;
    while (!done && cyc < 200) begin
      if (sum_valid) begin
        done = 1'b1;
      end else begin
        op_valid = toggle ? (cyc % 2 == 0) : 1'b1;
        if (op_ready && op_valid) begin
          op_data = base + step * 16'(hs);
          hs++;
          last = cyc;
        end
        if (!op_ready) begin
          low++;
          if (n_adds < 4) begin
            add_at[n_adds] = hs;
            n_adds++;
          end
        end
        tick();
        cyc++;
      end
    end
    op_valid = 1'b0;
    check_eq("run_timeout", 32'(done), 32'd1);
    lat = cyc - last;
  endtask

  task automatic take_sum();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_sum_valid", 32'(sum_valid), 32'd0);
  endtask

  initial begin
    int unsigned low;
    int unsigned lat;

    // Reset state
    tick();
    tick();
    check_eq("rst_op_ready", 32'(op_ready), 32'd0);
    check_eq("rst_sum_valid", 32'(sum_valid), 32'd0);
    check_eq("rst_sum_data", 32'(sum_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
`ifdef CSA_ACC_OVF_EN
    check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // 3 operands 1,2,3: single ADD, sum 6, 2-cycle latency
    do_run(3, 16'd1, 16'd1, 1'b0, low, lat);
    check_eq("r3_sum", 32'(sum_data), 32'd6);
    check_eq("r3_adds", low, 32'd1);
    check_eq("r3_add_at", add_at[0], 32'd3);
    check_eq("r3_lat", lat, 32'd2);
    check_eq("r3_busy", 32'(busy), 32'd1);
`ifdef CSA_ACC_OVF_EN
    check_eq("r3_ovf", 32'(ovf), 32'd0);
`endif
    take_sum();

    // num_ops = 0: DONE immediately with sum 0, op_ready never raised
    start   = 1'b1;
    num_ops = 8'd0;
    tick();
    start = 1'b0;
    check_eq("z_sum_valid", 32'(sum_valid), 32'd1);
    check_eq("z_sum_data", 32'(sum_data), 32'd0);
    check_eq("z_op_ready", 32'(op_ready), 32'd0);
    take_sum();

    // 20 operands 1..20: ADDs after handshakes 8, 16, 20; sum 210
    do_run(20, 16'd1, 16'd1, 1'b0, low, lat);
    check_eq("r20_sum", 32'(sum_data), 32'd210);
    check_eq("r20_ready_low", low, 32'd3);
    check_eq("r20_add0", add_at[0], 32'd8);
    check_eq("r20_add1", add_at[1], 32'd16);
    check_eq("r20_add2", add_at[2], 32'd20);
    check_eq("r20_lat", lat, 32'd2);
    take_sum();

    // 4 operands with gapped valid, then stalled DONE with an ignored start
    do_run(4, 16'd1, 16'd1, 1'b1, low, lat);
    check_eq("r4_sum", 32'(sum_data), 32'd10);
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      num_ops = 8'd0;
      tick();
      check_eq("stall_valid", 32'(sum_valid), 32'd1);
      check_eq("stall_data", 32'(sum_data), 32'd10);
    end
    start = 1'b0;
    take_sum();

    // 9 x 0xFFFF: wraps to 0xFFF7
    do_run(9, 16'hFFFF, 16'd0, 1'b0, low, lat);
    check_eq("r9_sum", 32'(sum_data), 32'h0000FFF7);
    check_eq("r9_adds", low, 32'd2);
`ifdef CSA_ACC_OVF_EN
    check_eq("r9_ovf", 32'(ovf), 32'd1);
`endif
    take_sum();

    // Reset mid-COLLECT abandons the run
    start   = 1'b1;
    num_ops = 8'd10;
    tick();
    start    = 1'b0;
    op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op_data = 16'(i + 1);
      tick();
    end
    op_valid = 1'b0;
    check_eq("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_op_ready", 32'(op_ready), 32'd0);
    check_eq("abort_sum_valid", 32'(sum_valid), 32'd0);

    // Fresh run after abort: 7 + 8
    do_run(2, 16'd7, 16'd1, 1'b0, low, lat);
    check_eq("r2_sum", 32'(sum_data), 32'd15);
    take_sum();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
